systolic_ctrl: RTL and testbench

Sequencer for a ROWS x COLS weight-stationary systolic array of `pe` instances. On `start` it loads one weight row per cycle from weight memory, then streams `num_vecs` activation vectors from activation memory with per-row skew enables. It drives the array-wide enable, tracks pipeline latency, tags each result vector leaving the bottom of the array, and supports back-pressure stall and weight reuse across jobs.

---
 rtl/systolic_ctrl.sv | 164 ++++++++++++++++
 tb/tb_systolic_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary systolic array: weight load,
// skewed activation streaming, latency-matched result tagging, stall and reuse.
module systolic_ctrl #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    num_vecs,
  input  logic                    reuse_w,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic                    w_rd_en,
  output logic [$clog2(ROWS)-1:0] w_rd_addr,
  output logic [ROWS-1:0]         wrow_ld,
  output logic                    a_rd_en,
  output logic [CNT_WIDTH-1:0]    a_rd_addr,
  output logic                    pe_en,
  output logic [ROWS-1:0]         row_valid,
  output logic                    out_valid,
  output logic [CNT_WIDTH-1:0]    out_idx
);

  localparam int unsigned LAT = 1 + ROWS + COLS - 1;
  localparam int unsigned AW  = $clog2(ROWS);
  localparam int unsigned XW  = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] nv_q, nv_d;
  logic [CNT_WIDTH-1:0] issue_q, issue_d;
  logic [XW-1:0]        aux_q, aux_d;
  logic [LAT-1:0]       vld_q;
  logic [CNT_WIDTH-1:0] idx_q [LAT];
  logic                 adv;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      nv_q    <= '0;
      issue_q <= '0;
      aux_q   <= '0;
    end else begin
      state_q <= state_d;
      nv_q    <= nv_d;
      issue_q <= issue_d;
      aux_q   <= aux_d;
    end
  end

  // Next-state and control decode; aux_q counts load steps, then drain steps
  always_comb begin
    state_d   = state_q;
    nv_d      = nv_q;
    issue_d   = issue_q;
    aux_d     = aux_q;
    busy      = 1'b0;
    done      = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    wrow_ld   = '0;
    a_rd_en   = 1'b0;
    a_rd_addr = '0;
    pe_en     = 1'b0;
    adv       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          nv_d    = num_vecs;
          issue_d = '0;
          aux_d   = '0;
          if (num_vecs == '0) begin
            state_d = DONE;
          end else if (reuse_w) begin
            state_d = STREAM;
          end else begin
            state_d = LOAD_W;
          end
        end
      end
      LOAD_W: begin
        busy = 1'b1;
        if (aux_q < XW'(ROWS)) begin
          w_rd_en   = 1'b1;
          w_rd_addr = AW'(aux_q);
        end
        // Row strobe trails its read by one cycle to match memory latency
        for (int r = 0; r < ROWS; r++) begin
          wrow_ld[r] = (aux_q == XW'(r + 1));
        end
        if (aux_q == XW'(ROWS)) begin
          state_d = STREAM;
          aux_d   = '0;
        end else begin
          aux_d = aux_q + XW'(1);
        end
      end
      STREAM: begin
        busy = 1'b1;
        if (!stall) begin
          pe_en     = 1'b1;
          a_rd_en   = 1'b1;
          a_rd_addr = issue_q;
          adv       = 1'b1;
          if (issue_q == nv_q - CNT_WIDTH'(1)) begin
            state_d = DRAIN;
            aux_d   = '0;
          end else begin
            issue_d = issue_q + CNT_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!stall) begin
          pe_en = 1'b1;
          adv   = 1'b1;
          if (aux_q == XW'(LAT - 1)) begin
            state_d = DONE;
          end else begin
            aux_d = aux_q + XW'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Skew and result delay lines; they only advance on unstalled active cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        idx_q[i] <= '0;
      end
    end else if (adv) begin
      vld_q    <= {vld_q[LAT-2:0], a_rd_en};
      idx_q[0] <= issue_q;
      for (int i = 1; i < LAT; i++) begin
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign row_valid = adv ? vld_q[ROWS-1:0] : '0;
  assign out_valid = adv & vld_q[LAT-1];
  assign out_idx   = out_valid ? idx_q[LAT-1] : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (ROWS=COLS=4, LAT=8): a per-cycle vector
// table for load/reuse/back-to-back jobs plus sequences for stall, reset, empty job.
module tb_systolic_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vecs;
  logic        reuse_w;
  logic        stall;
  logic        busy, done, w_rd_en, a_rd_en, pe_en, out_valid;
  logic [1:0]  w_rd_addr;
  logic [3:0]  wrow_ld, row_valid;
  logic [15:0] a_rd_addr, out_idx;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_ctrl #(.ROWS(4), .COLS(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs), .reuse_w(reuse_w),
    .stall(stall), .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .wrow_ld(wrow_ld), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .pe_en(pe_en),
    .row_valid(row_valid), .out_valid(out_valid), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wen;
    logic [1:0]  waddr;
    logic [3:0]  wld;
    logic        aen;
    logic [15:0] aaddr;
    logic        pe;
    logic [3:0]  rv;
    logic        ov;
    logic [15:0] oidx;
  } out_t;

  typedef struct {
    logic        start;
    logic [15:0] nv;
    logic        reuse;
    logic        stall;
    out_t        exp;
  } vec_t;

  vec_t tbl[$];

  function automatic out_t o(input logic b, input logic d, input logic we, input int wa,
                             input logic [3:0] wl, input logic ae, input int aa,
                             input logic pe, input logic [3:0] rv, input logic ov,
                             input int oi);
    out_t r;
    r.busy = b; r.done = d; r.wen = we; r.waddr = 2'(wa); r.wld = wl;
    r.aen = ae; r.aaddr = 16'(aa); r.pe = pe; r.rv = rv; r.ov = ov; r.oidx = 16'(oi);
    return r;
  endfunction

  function automatic out_t act_out();
    out_t r;
    r.busy = busy; r.done = done; r.wen = w_rd_en; r.waddr = w_rd_addr; r.wld = wrow_ld;
    r.aen = a_rd_en; r.aaddr = a_rd_addr; r.pe = pe_en; r.rv = row_valid;
    r.ov = out_valid; r.oidx = out_idx;
    return r;
  endfunction

  task automatic add(input logic s, input int nv, input logic ru, input logic st, input out_t e);
    vec_t v;
    v.start = s; v.nv = 16'(nv); v.reuse = ru; v.stall = st; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and settle before sampling
  task automatic cyc(input logic s, input int nv, input logic ru, input logic st);
    @(negedge clk);
    start = s; num_vecs = 16'(nv); reuse_w = ru; stall = st;
    #1;
  endtask

  // Reused 2-vector reuse job checker: outputs must be in order, done at a fixed cycle
  task automatic run_small(input string nm, input int nv, input int done_at);
    int k;
    int dcnt;
    k = 0; dcnt = 0;
    cyc(1'b1, nv, 1'b1, 1'b0);
    for (int c = 1; c <= done_at + 3; c++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      if (out_valid) begin
        chk({nm, "_oidx"}, 64'(out_idx), 64'(k));
        chk({nm, "_ocyc"}, 64'(c), 64'(1 + 8 + k));
        k++;
      end
      if (done) begin
        chk({nm, "_done"}, 64'(c), 64'(done_at));
        dcnt++;
      end
    end
    chk({nm, "_nout"}, 64'(k), 64'(nv));
    chk({nm, "_ndone"}, 64'(dcnt), 64'(1));
  endtask

  out_t z;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nad, dcnt;
    int ocyc[5];
    out_t zero;
    z = '0;
    zero = '0;
    rst = 1'b1; start = 1'b0; num_vecs = '0; reuse_w = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Job A: full load, 3 vectors; stray start at cycle 10 must be ignored
    add(1, 3, 0, 0, z);
    add(0, 0, 0, 0, o(1,0,1,0,4'b0000,0,0,0,4'b0000,0,0));
    add(0, 0, 0, 0, o(1,0,1,1,4'b0001,0,0,0,4'b0000,0,0));
    add(0, 0, 0, 0, o(1,0,1,2,4'b0010,0,0,0,4'b0000,0,0));
    add(0, 0, 0, 0, o(1,0,1,3,4'b0100,0,0,0,4'b0000,0,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b1000,0,0,0,4'b0000,0,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,1,0,1,4'b0000,0,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,1,1,1,4'b0001,0,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,1,2,1,4'b0011,0,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0111,0,0));
    add(1, 7, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b1110,0,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b1100,0,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b1000,0,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0000,0,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0000,1,0));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0000,1,1));
    add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0000,1,2));
    add(0, 0, 0, 0, o(0,1,0,0,4'b0000,0,0,0,4'b0000,0,0));
    add(0, 0, 0, 0, z);
    // Jobs B and C: reuse, 1 vector, C starts the cycle after B's done
    for (int j = 0; j < 2; j++) begin
      add(1, 1, 1, 0, z);
      add(0, 0, 0, 0, o(1,0,0,0,4'b0000,1,0,1,4'b0000,0,0));
      add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0001,0,0));
      add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0010,0,0));
      add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0100,0,0));
      add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b1000,0,0));
      add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0000,0,0));
      add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0000,0,0));
      add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0000,0,0));
      add(0, 0, 0, 0, o(1,0,0,0,4'b0000,0,0,1,4'b0000,1,0));
      add(j == 0, 1, 1, 0, o(0,1,0,0,4'b0000,0,0,0,4'b0000,0,0));
    end
    add(0, 0, 0, 0, z);

    chk("reset_state", 64'(act_out()), 64'(zero));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].start, 32'(tbl[i].nv), tbl[i].reuse, tbl[i].stall);
      chk($sformatf("vec%0d", i), 64'(act_out()), 64'(tbl[i].exp));
    end

    // Stall: 3 cycles mid-STREAM, 2 in DRAIN; done 5 cycles after the unstalled point
    ocyc = '{14, 15, 16, 17, 18};
    k = 0; nad = 0; dcnt = 0;
    cyc(1'b1, 5, 1'b1, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      cyc(1'b0, 0, 1'b0, (c inside {3, 4, 5, 11, 12}));
      if (stall) chk($sformatf("stall_gate_c%0d", c),
                     64'({a_rd_en, pe_en, row_valid, out_valid}), 64'(0));
      if (a_rd_en) begin
        chk("stall_addr", 64'(a_rd_addr), 64'(nad));
        nad++;
      end
      if (out_valid) begin
        chk("stall_oidx", 64'(out_idx), 64'(k));
        if (k < 5) chk("stall_ocyc", 64'(c), 64'(ocyc[k]));
        k++;
      end
      if (done) begin
        chk("stall_done", 64'(c), 64'(19));
        dcnt++;
      end
    end
    chk("stall_nout", 64'(k), 64'(5));
    chk("stall_nissue", 64'(nad), 64'(5));
    chk("stall_ndone", 64'(dcnt), 64'(1));

    // Reset mid-STREAM at issue 5, then a clean 2-vector job
    cyc(1'b1, 10, 1'b1, 1'b0);
    for (int c = 1; c <= 6; c++) cyc(1'b0, 0, 1'b0, 1'b0);
    chk("rst_pre_addr", 64'(a_rd_addr), 64'(5));
    rst = 1'b1;
    cyc(1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_outs", 64'(act_out()), 64'(zero));
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("rst_idle", 64'(act_out()), 64'(zero));
    run_small("after_rst", 2, 11);

    // Empty job: done the next cycle, never busy, no reads
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("nv0_done", 64'(act_out()), 64'(o(0,1,0,0,4'b0000,0,0,0,4'b0000,0,0)));
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("nv0_idle", 64'(act_out()), 64'(zero));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
